// File: rtl/data_sram_arb_2x1.sv
// Two-master arbiter for a single-port synchronous data SRAM, with lock bursts and tagged read return.
// Build option: DATA_SRAM_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module data_sram_arb_2x1 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [WEN_W-1:0]  m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [WEN_W-1:0]  m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_en,
  output logic [WEN_W-1:0]  sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_e;

  sel_e              owner;
  sel_e              rd_tag;
  sel_e              win_sel;
  logic              prio_fav;
  logic              g0;
  logic              g1;
  logic              hold0;
  logic              hold1;
  logic              win_lock;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

`ifdef DATA_SRAM_ARB_FIXED_PRIO_EN
  assign prio_fav = 1'b0;
`else
  logic prio_q;
  assign prio_fav = prio_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else if (g0 || g1) begin
      prio_q <= g0;
    end
  end
`endif

  // An owner keeps exclusivity while it locks or still requests; an owner
  // requesting with lock low gets this final access and releases on the same edge.
  always_comb begin
    hold0 = (owner == SEL_M0) && (m0_req || m0_lock);
    hold1 = (owner == SEL_M1) && (m1_req || m1_lock);
    g0    = 1'b0;
    g1    = 1'b0;
    if (!reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end else if (hold0) begin
      g0 = m0_req;
    end else if (hold1) begin
      g1 = m1_req;
    end else if (m0_req && m1_req) begin
      g0 = !prio_fav;
      g1 = prio_fav;
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    win_sel    = SEL_NONE;
    win_lock   = 1'b0;
    if (g0) begin
      sram_en    = 1'b1;
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
      win_sel    = SEL_M0;
      win_lock   = m0_lock;
    end else if (g1) begin
      sram_en    = 1'b1;
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
      win_sel    = SEL_M1;
      win_lock   = m1_lock;
    end
  end

  assign m0_gnt = g0;
  assign m1_gnt = g1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner        <= SEL_NONE;
      rd_tag       <= SEL_NONE;
      conflict_cnt <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      if (sram_en) begin
        owner <= win_lock ? win_sel : SEL_NONE;
      end else if ((owner == SEL_M0 && !m0_lock) || (owner == SEL_M1 && !m1_lock)) begin
        owner <= SEL_NONE;
      end
      rd_tag <= (sram_en && (sram_wen == '0)) ? win_sel : SEL_NONE;
      if (m0_req && m1_req && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (rd_tag == SEL_M0) begin
        rdata0_q <= sram_rdata;
      end
      if (rd_tag == SEL_M1) begin
        rdata1_q <= sram_rdata;
      end
    end
  end

  // Returned data passes straight through in the return cycle and is held afterwards.
  assign m0_rvalid = (rd_tag == SEL_M0);
  assign m1_rvalid = (rd_tag == SEL_M1);
  assign m0_rdata  = m0_rvalid ? sram_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? sram_rdata : rdata1_q;

endmodule

// File: tb/tb_data_sram_arb_2x1.sv
// Table-driven bench for data_sram_arb_2x1 with a behavioural SRAM and a read-return scoreboard.
module tb_data_sram_arb_2x1;

  typedef struct {
    logic        rst_n;
    logic        r0;
    logic [3:0]  w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        l0;
    logic        r1;
    logic [3:0]  w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        l1;
    logic        e0;
    logic        e1;
  } vec_t;

  typedef struct {
    logic        m;
    logic [31:0] d;
    int          due;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
  logic [3:0]  m0_wen;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]  m1_wen;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  vec_t        vecs[$];
  sb_t         sb[$];
  int          checks;
  int          failures;
  int          cyc;
  logic [15:0] cnt_exp;
  logic [31:0] last0;
  logic [31:0] last1;

  data_sram_arb_2x1 #(.ADDR_W(32), .DATA_W(32), .WEN_W(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    logic [15:0] lo;
    lo = i[15:0];
    return (i == 4) ? 32'hA5A5_0001 : {16'h5A5A, lo};
  endfunction

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'h0) begin
        sram_rdata <= mem[sram_addr[13:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wen[b]) mem[sram_addr[13:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end
    end
  end

  function automatic vec_t mk(input logic rst, input logic r0, input logic [3:0] w0,
                              input logic [31:0] a0, input logic [31:0] d0, input logic l0,
                              input logic r1, input logic [3:0] w1, input logic [31:0] a1,
                              input logic [31:0] d1, input logic l1, input logic e0, input logic e1);
    vec_t v;
    v.rst_n = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    for (int b = 0; b < 4; b++) begin
      if (w[b]) ref_mem[a[13:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic step(input vec_t v);
    logic ex_rv0;
    logic ex_rv1;
    sb_t  e;
    @(posedge clk);
    #1;
    reset = v.rst_n;
    m0_req = v.r0; m0_wen = v.w0; m0_addr = v.a0; m0_wdata = v.d0; m0_lock = v.l0;
    m1_req = v.r1; m1_wen = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.l1;
    @(negedge clk);
    cyc++;
    if (!v.rst_n) begin
      sb.delete();
      cnt_exp = 16'h0;
      last0 = 32'h0;
      last1 = 32'h0;
    end
    ex_rv0 = 1'b0;
    ex_rv1 = 1'b0;
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.m == 1'b0) begin ex_rv0 = 1'b1; last0 = e.d; end
      else             begin ex_rv1 = 1'b1; last1 = e.d; end
    end
    chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, v.e0});
    chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, v.e1});
    chk("sram_en", {31'b0, sram_en}, {31'b0, v.e0 | v.e1});
    if (v.e0) begin
      chk("sram_addr_m0", sram_addr, v.a0);
      chk("sram_wen_m0", {28'b0, sram_wen}, {28'b0, v.w0});
      if (v.w0 != 4'h0) chk("sram_wdata_m0", sram_wdata, v.d0);
    end else if (v.e1) begin
      chk("sram_addr_m1", sram_addr, v.a1);
      chk("sram_wen_m1", {28'b0, sram_wen}, {28'b0, v.w1});
      if (v.w1 != 4'h0) chk("sram_wdata_m1", sram_wdata, v.d1);
    end
    if (!v.rst_n) begin
      chk("rst_sram_addr", sram_addr, 32'h0);
      chk("rst_sram_wdata", sram_wdata, 32'h0);
      chk("rst_sram_wen", {28'b0, sram_wen}, 32'h0);
    end
    chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, ex_rv0});
    chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, ex_rv1});
    chk("m0_rdata", m0_rdata, last0);
    chk("m1_rdata", m1_rdata, last1);
    chk("conflict_cnt", {16'b0, conflict_cnt}, {16'b0, cnt_exp});
    if (v.e0) begin
      if (v.w0 == 4'h0) sb.push_back('{m: 1'b0, d: ref_mem[v.a0[13:2]], due: cyc + 1});
      else              model_write(v.a0, v.d0, v.w0);
    end
    if (v.e1) begin
      if (v.w1 == 4'h0) sb.push_back('{m: 1'b1, d: ref_mem[v.a1[13:2]], due: cyc + 1});
      else              model_write(v.a1, v.d1, v.w1);
    end
    if (v.rst_n && v.r0 && v.r1 && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; cnt_exp = 16'h0; last0 = 32'h0; last1 = 32'h0;
    reset = 1'b0;
    m0_req = 1'b0; m0_wen = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_wen = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_lock = 1'b0;
    sram_rdata = 32'h0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end

    // Reset, then both masters reading continuously.
    vecs.push_back(mk(1'b0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0));
`ifdef DATA_SRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h40 + 32'(4 * i), 32'h0, 1'b0,
                        1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0));
    end
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1));
`else
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h44, 32'h0, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h44, 32'h0, 1'b0, 1'b1, 4'h0, 32'h84, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h48, 32'h0, 1'b0, 1'b1, 4'h0, 32'h84, 32'h0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h48, 32'h0, 1'b0, 1'b1, 4'h0, 32'h88, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h4C, 32'h0, 1'b0, 1'b1, 4'h0, 32'h88, 32'h0, 1'b0, 1'b0, 1'b1));
`endif
    vecs.push_back(idle());
    // Single m0 read of the preloaded word.
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(idle());
    // m1 write followed by m0 read-back.
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(idle());
    // m1 lock burst: m0 waits, including an idle owner cycle, then is granted.
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 4'h0, 32'h108, 32'h0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b1, 4'h0, 32'h10C, 32'h0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 1'b1, 1'b0));
    // Owner requesting with lock low gets its last access and releases.
    vecs.push_back(mk(1'b1, 1'b0, 4'h0, 32'h0,  32'h0, 1'b0, 1'b1, 4'h0, 32'h110, 32'h0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h18, 32'h0, 1'b0, 1'b1, 4'h0, 32'h114, 32'h0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 4'h0, 32'h18, 32'h0, 1'b0, 1'b1, 4'h0, 32'h118, 32'h0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(idle());

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset during a pending read: no return, outputs cleared, priority back to m0.
    step(mk(1'b1, 1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
    step(mk(1'b0, 1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 1'b1, 4'h0, 32'h90, 32'h0, 1'b0, 1'b0, 1'b0));
    chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    step(mk(1'b1, 1'b1, 4'hF, 32'h200, 32'h1111_2222, 1'b0, 1'b1, 4'hF, 32'h204, 32'h3333_4444, 1'b0, 1'b1, 1'b0));
    step(idle());
    step(idle());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
